// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered-output ALU among four requesters.
// Each granted operation runs IDLE -> EXEC -> CAPT -> RESP and returns its result with the owner ID.
module alu_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  input  logic [N_REQ*3-1:0]       req_sel,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [1:0]               rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_select,
  input  logic [WIDTH-1:0]         alu_f,
  output logic                     busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StCapt = 2'd2,
    StResp = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         last_grant_q;
  logic [1:0]         rsp_id_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic [WIDTH-1:0]   alu_a_q, alu_b_q;
  logic [2:0]         alu_select_q;

  logic               any_valid;
  logic [1:0]         winner;
  logic [1:0]         cand;
  logic               grant;
  logic               capture;

  // Scan from lowest to highest priority so the highest-priority valid requester is kept last.
  always_comb begin
    winner    = '0;
    cand      = '0;
    any_valid = |req_valid;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = last_grant_q + 2'(k);
      if (req_valid[cand]) begin
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    grant     = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          req_ready[winner] = 1'b1;
          grant             = 1'b1;
          state_d           = StExec;
        end
      end
      StExec: state_d = StCapt;
      StCapt: begin
        capture = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 2'd3;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_select_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        last_grant_q <= winner;
        rsp_id_q     <= winner;
        alu_a_q      <= req_a[winner*WIDTH +: WIDTH];
        alu_b_q      <= req_b[winner*WIDTH +: WIDTH];
        alu_select_q <= req_sel[winner*3 +: 3];
      end
      if (capture) begin
        rsp_data_q <= alu_f;
      end
    end
  end

  assign rsp_valid  = (state_q == StResp);
  assign busy       = (state_q != StIdle);
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_select = alu_select_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, transaction-level arbiter model, directed and random stimulus.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [11:0] req_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_select;
  logic [15:0] alu_f = '0;
  logic        busy;

  int n_cmp = 0;
  int n_mis = 0;

  // Model state
  bit          m_idle = 1'b1;
  int          m_last = 3;
  int          m_age  = 0;
  logic [1:0]  m_id;
  logic [15:0] m_data, m_a;
  logic [3:0]  g_vec = '0;
  bit          hs = 1'b0;
  logic [15:0] last_rsp;
  logic [1:0]  last_id;

  alu_arbiter u_dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .alu_f      (alu_f),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] s);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return ~a;
      3'd3:    return ~b;
      3'd4:    return (a > b) ? 16'd1 : 16'd0;
      default: return a + b;
    endcase
  endfunction

  // Shared ALU with one registered output stage.
  always_ff @(posedge clk) alu_f <= alu_ref(alu_a, alu_b, alu_select);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model_check();
    int  w;
    bit  found;
    g_vec = '0;
    hs    = 1'b0;
    if (m_idle) begin
      found = 1'b0;
      w     = 0;
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (!found && req_valid[c]) begin
          found = 1'b1;
          w     = c;
        end
      end
      check("ready", 32'(req_ready), found ? (32'd1 << w) : 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check("valid_idle", 32'(rsp_valid), 32'd0);
      if (found) begin
        m_idle = 1'b0;
        m_age  = 0;
        m_last = w;
        m_id   = 2'(w);
        m_a    = req_a[w*16 +: 16];
        m_data = alu_ref(m_a, req_b[w*16 +: 16], req_sel[w*3 +: 3]);
        g_vec  = req_ready & req_valid;
      end
    end else begin
      m_age++;
      check("ready_busy", 32'(req_ready), 32'd0);
      check("busy", 32'(busy), 32'd1);
      check("rsp_valid", 32'(rsp_valid), (m_age >= 3) ? 32'd1 : 32'd0);
      if (m_age >= 3) begin
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_data", 32'(rsp_data), 32'(m_data));
        check("alu_a_hold", 32'(alu_a), 32'(m_a));
        if (rsp_ready) begin
          hs       = 1'b1;
          m_idle   = 1'b1;
          last_rsp = rsp_data;
          last_id  = rsp_id;
        end
      end
    end
  endtask

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] s);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
    req_sel[i*3 +: 3] = s;
  endtask

  task automatic wait_grant(input int i, input string tag);
    int n = 0;
    step();
    while (!g_vec[i] && n < 40) begin
      step();
      n++;
    end
    if (!g_vec[i]) check(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_hs(input string tag);
    int n = 0;
    step();
    while (!hs && n < 40) begin
      step();
      n++;
    end
    if (!hs) check(tag, 32'd0, 32'd1);
  endtask

  task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] s);
    set_op(i, a, b, s);
    req_valid[i] = 1'b1;
    wait_grant(i, "grant_timeout");
    req_valid[i] = 1'b0;
    wait_hs("rsp_timeout");
  endtask

  task automatic do_reset();
    req_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_idle = 1'b1;
    m_last = 3;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) step();
  endtask

  initial begin
    int got_order[$];
    int cnt;
    logic [1:0]  bp_id;
    logic [15:0] bp_data;

    #1 reset = 1'b1;
    #3;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_alu", {alu_a, alu_b}, 32'd0);
    check("rst_sel", 32'(alu_select), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    rsp_ready = 1'b1;

    // Single add
    run_op(0, 16'h0003, 16'h0005, 3'd0);
    check("add", 32'(last_rsp), 32'h0008);
    check("add_id", 32'(last_id), 32'd0);

    // Wrap and compare
    run_op(2, 16'h0000, 16'h0001, 3'd1);
    check("sub_wrap", 32'(last_rsp), 32'hFFFF);
    check("sub_id", 32'(last_id), 32'd2);
    run_op(2, 16'h0005, 16'h0003, 3'd4);
    check("gt_true", 32'(last_rsp), 32'h0001);
    run_op(2, 16'h0003, 16'h0005, 3'd4);
    check("gt_false", 32'(last_rsp), 32'h0000);
    run_op(2, 16'hFFFF, 16'h0002, 3'd7);
    check("sel7_add", 32'(last_rsp), 32'h0001);

    // Round robin with all four valid from reset
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 16'(i * 16 + 1), 16'(i + 2), 3'(i));
    req_valid = 4'hF;
    cnt = 0;
    while (got_order.size() < 8 && cnt < 200) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (g_vec[i]) begin
          got_order.push_back(i);
          set_op(i, 16'($urandom), 16'($urandom), 3'($urandom));
        end
      end
      cnt++;
    end
    for (int k = 0; k < 8; k++) check("rr_all", 32'(got_order[k]), 32'(k % 4));
    got_order.delete();
    req_valid = 4'b1010;
    cnt = 0;
    while (got_order.size() < 4 && cnt < 200) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (g_vec[i]) begin
          got_order.push_back(i);
          set_op(i, 16'($urandom), 16'($urandom), 3'($urandom));
        end
      end
      cnt++;
    end
    for (int k = 0; k < 4; k++) check("rr_1_3", 32'(got_order[k]), (k % 2 == 0) ? 32'd1 : 32'd3);
    drain();

    // Backpressure
    rsp_ready = 1'b0;
    set_op(0, 16'h1234, 16'h1111, 3'd1);
    req_valid[0] = 1'b1;
    wait_grant(0, "bp_grant");
    req_valid[0] = 1'b0;
    cnt = 0;
    while (!rsp_valid && cnt < 10) begin
      step();
      cnt++;
    end
    bp_id   = rsp_id;
    bp_data = rsp_data;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold", {14'd0, rsp_id, rsp_data}, {14'd0, bp_id, bp_data});
    end
    check("bp_data", 32'(bp_data), 32'h0123);
    rsp_ready = 1'b1;
    set_op(1, 16'h0002, 16'h0003, 3'd0);
    req_valid[1] = 1'b1;
    step();
    check("bp_hs", 32'(hs), 32'd1);
    step();
    check("bp_next_grant", 32'(g_vec), 32'b0010);
    req_valid[1] = 1'b0;
    wait_hs("bp_rsp2");

    // Reset mid-operation (in EXEC)
    set_op(2, 16'h00AA, 16'h0055, 3'd0);
    req_valid[2] = 1'b1;
    wait_grant(2, "mr_grant");
    req_valid[2] = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_valid", 32'(rsp_valid), 32'd0);
    check("mr_alu", {alu_a, alu_b}, 32'd0);
    check("mr_sel", 32'(alu_select), 32'd0);
    check("mr_id", 32'(rsp_id), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    m_idle = 1'b1;
    m_last = 3;
    set_op(0, 16'h0010, 16'h0001, 3'd1);
    set_op(1, 16'h0020, 16'h0002, 3'd0);
    req_valid = 4'b0011;
    step();
    check("mr_first", 32'(g_vec), 32'b0001);
    req_valid[0] = 1'b0;
    wait_grant(1, "mr_second");
    drain();

    // Request withdrawal during RESP
    rsp_ready = 1'b0;
    set_op(0, 16'h0007, 16'h0008, 3'd0);
    req_valid[0] = 1'b1;
    wait_grant(0, "wd_grant");
    req_valid[0] = 1'b0;
    cnt = 0;
    while (!rsp_valid && cnt < 10) begin
      step();
      cnt++;
    end
    set_op(3, 16'h0001, 16'h0001, 3'd0);
    req_valid[3] = 1'b1;
    step();
    req_valid[3] = 1'b0;
    step();
    rsp_ready = 1'b1;
    wait_hs("wd_hs");
    step();
    step();
    req_valid = 4'b0011;
    step();
    check("wd_last_grant", 32'(g_vec), 32'b0010);
    drain();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (g_vec[i] || !req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            set_op(i, 16'($urandom), 16'($urandom), 3'($urandom));
            req_valid[i] = 1'b1;
          end else begin
            req_valid[i] = 1'b0;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
